regfile_wb_queue: RTL

//  Write-back side of the register file. Merges two result producers into the single regfile

---
 rtl/regfile_wb_queue_pkg.sv | 13 +
 rtl/regfile_wb_queue_match.sv | 40 ++++
 rtl/regfile_wb_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared sizing for the register-file write-back queue.
package regfile_wb_queue_pkg;

  localparam int unsigned WBQ_DATA_W = 32;  // register data width
  localparam int unsigned WBQ_ADDR_W = 5;   // register address width
  localparam int unsigned WBQ_DEPTH  = 4;   // queue entries, power of two

  // Pointer width for a power-of-two queue of the given depth.
  function automatic int unsigned wbq_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_wb_queue_match.sv
// Youngest-match scan over the occupied queue entries for one lookup port.
module wbq_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_W = WBQ_DATA_W,
  parameter int unsigned ADDR_W = WBQ_ADDR_W,
  parameter int unsigned DEPTH  = WBQ_DEPTH
) (
  input  logic [ADDR_W-1:0]            addr_i [DEPTH],
  input  logic [DATA_W-1:0]            data_i [DEPTH],
  input  logic [wbq_ptr_w(DEPTH)-1:0]  head_i,
  input  logic [wbq_ptr_w(DEPTH):0]    count_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  localparam int unsigned PTR_W = wbq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_i + PTR_W'(i);
      if (CNT_W'(i) < count_i) begin
        if ((raddr_i != '0) && (addr_i[idx] == raddr_i)) begin
          hit_o  = 1'b1;
          data_o = data_i[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue: merges an in-order result (A) and a multi-cycle result (B)
// into the single regfile write port, draining one entry per cycle, with two
// forwarding lookups over the still-pending writes.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_W = WBQ_DATA_W,
  parameter int unsigned ADDR_W = WBQ_ADDR_W,
  parameter int unsigned DEPTH  = WBQ_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic                        a_wreg,
  input  logic [ADDR_W-1:0]           a_waddr,
  input  logic [DATA_W-1:0]           a_wdata,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic                        b_wreg,
  input  logic [ADDR_W-1:0]           b_waddr,
  input  logic [DATA_W-1:0]           b_wdata,
  output logic                        we,
  output logic [ADDR_W-1:0]           waddr,
  output logic [DATA_W-1:0]           wdata,
  input  logic [ADDR_W-1:0]           q_raddr1,
  output logic                        q_hit1,
  output logic [DATA_W-1:0]           q_data1,
  input  logic [ADDR_W-1:0]           q_raddr2,
  output logic                        q_hit2,
  output logic [DATA_W-1:0]           q_data2,
  output logic [wbq_ptr_w(DEPTH):0]   count
);

  localparam int unsigned PTR_W = wbq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] b_slot;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   free_slots;
  logic [CNT_W:0]   b_need;
  logic             a_qual, b_qual;
  logic             enq_a, enq_b, pop;

  // Acceptance, enqueue/pop decisions and next pointer/count values.
  always_comb begin
    a_qual     = a_valid & a_wreg & (a_waddr != '0);
    b_qual     = b_valid & b_wreg & (b_waddr != '0);
    pop        = (count_q != '0);
    // The head leaving this edge frees its slot; pop depends only on count.
    free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    b_need     = (CNT_W+1)'(1) + (CNT_W+1)'(a_qual);
    a_ready    = !rst && (free_slots >= (CNT_W+1)'(1));
    b_ready    = !rst && (free_slots >= b_need);
    enq_a      = a_qual & a_ready;
    enq_b      = b_qual & b_ready;
    b_slot     = wr_ptr_q + PTR_W'(enq_a);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(enq_a) + PTR_W'(enq_b);
    count_d    = count_q + CNT_W'(enq_a) + CNT_W'(enq_b) - CNT_W'(pop);
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; A takes the older slot when both enqueue together.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy comes from the pointers and count alone.
    if (enq_a) begin
      addr_mem[wr_ptr_q] <= a_waddr;
      data_mem[wr_ptr_q] <= a_wdata;
    end
    if (enq_b) begin
      addr_mem[b_slot] <= b_waddr;
      data_mem[b_slot] <= b_wdata;
    end
  end

  // Head entry drives the regfile port; an empty queue drives zeros.
  always_comb begin
    we    = pop;
    waddr = pop ? addr_mem[rd_ptr_q] : '0;
    wdata = pop ? data_mem[rd_ptr_q] : '0;
    count = count_q;
  end

  wbq_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_match1 (
    .addr_i  (addr_mem),
    .data_i  (data_mem),
    .head_i  (rd_ptr_q),
    .count_i (count_q),
    .raddr_i (q_raddr1),
    .hit_o   (q_hit1),
    .data_o  (q_data1)
  );

  wbq_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_match2 (
    .addr_i  (addr_mem),
    .data_i  (data_mem),
    .head_i  (rd_ptr_q),
    .count_i (count_q),
    .raddr_i (q_raddr2),
    .hit_o   (q_hit2),
    .data_o  (q_data2)
  );

endmodule
